// File: rtl/issue_pkg.sv
// Shared definitions for the issue controller: opcode/funct encodings, field
// positions, scoreboard entry layout and the head-instruction decoder.
package issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h03;
  localparam logic [5:0] OP_SUBI  = 6'h02;
  localparam logic [5:0] OP_XORI  = 6'h01;
  localparam logic [5:0] OP_ANDI  = 6'h0F;
  localparam logic [5:0] OP_ORI   = 6'h0C;

  localparam logic [5:0] F_ADD = 6'h03;
  localparam logic [5:0] F_SUB = 6'h02;
  localparam logic [5:0] F_XOR = 6'h01;
  localparam logic [5:0] F_AND = 6'h07;
  localparam logic [5:0] F_OR  = 6'h04;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
  } sb_entry_t;

  typedef struct packed {
    reg_idx_t rs;
    reg_idx_t rt;
    logic     uses_rt;
    logic     alloc;
    reg_idx_t dest;
  } dec_t;

  // Sources are taken from the format (R or I) even for unsupported
  // encodings; only scoreboard allocation depends on the op/funct being known.
  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t       d;
    logic [5:0] op;
    logic [5:0] fn;
    op        = instr[OP_HI:OP_LO];
    fn        = instr[FN_HI:FN_LO];
    d.rs      = instr[RS_HI:RS_LO];
    d.rt      = instr[RT_HI:RT_LO];
    d.uses_rt = 1'b0;
    d.alloc   = 1'b0;
    d.dest    = instr[RT_HI:RT_LO];
    if (op == OP_RTYPE) begin
      d.uses_rt = 1'b1;
      d.dest    = instr[RD_HI:RD_LO];
      case (fn)
        F_ADD, F_SUB, F_XOR, F_AND, F_OR: d.alloc = 1'b1;
        default:                          d.alloc = 1'b0;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_SUBI, OP_XORI, OP_ANDI, OP_ORI: d.alloc = 1'b1;
        default:                                     d.alloc = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Instruction-in / instruction-out bus of the issue controller.
interface issue_ctrl_if;
  // Upstream: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready does not depend on in_valid. Downstream has no back-pressure:
  // out_valid marks a real instruction, otherwise out_instr is a NOP (0).
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;

  modport master (
    output in_valid,
    output in_instr,
    input  in_ready,
    input  out_valid,
    input  out_instr
  );

  modport slave (
    input  in_valid,
    input  in_instr,
    output in_ready,
    output out_valid,
    output out_instr
  );
endinterface

// File: rtl/issue_fifo.sv
// Power-of-two instruction FIFO with wrap-bit pointers; the head word is
// visible combinationally so the issue logic can decode it before popping.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A push while full is dropped even if the head pops in the same cycle.
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: queues instructions, holds the head while a source is
// still being produced, and drives one instruction or a NOP per cycle.
module issue_ctrl
  import issue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WB_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  issue_ctrl_if.slave       bus,
  output logic [15:0]       stall_count
);

  logic        w_full;
  logic        w_empty;
  logic [31:0] w_head;
  dec_t        w_dec;
  logic        w_blocked;
  logic        w_issue;
  logic        w_stall;

  sb_entry_t   r_sb [1:WB_LAT];
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [15:0] r_stall_count;

  issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (bus.in_valid),
    .i_data  (bus.in_instr),
    .i_pop   (w_issue),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign bus.in_ready = !w_full;
  assign w_dec        = decode_instr(w_head);

  // A producer sitting in sb[WB_LAT] has its result written back by the time
  // the consumer reads operands, so only stages 1..WB_LAT-1 hold the head.
  always_comb begin
    w_blocked = 1'b0;
    for (int k = 1; k < WB_LAT; k++) begin
      if (r_sb[k].valid &&
          ((r_sb[k].dest == w_dec.rs) ||
           (w_dec.uses_rt && (r_sb[k].dest == w_dec.rt)))) begin
        w_blocked = 1'b1;
      end
    end
  end

  assign w_issue = !w_empty && !w_blocked && !flush;
  assign w_stall = !w_empty && w_blocked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= WB_LAT; k++) r_sb[k] <= '0;
    end else if (flush) begin
      for (int k = 1; k <= WB_LAT; k++) r_sb[k] <= '0;
    end else begin
      r_sb[1].valid <= w_issue && w_dec.alloc;
      r_sb[1].dest  <= w_dec.dest;
      for (int k = 2; k <= WB_LAT; k++) r_sb[k] <= r_sb[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0;
    end else begin
      r_out_valid <= w_issue;
      r_out_instr <= w_issue ? w_head : 32'h0;
    end
  end

  // Stall cycles are a performance counter: flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= 16'h0;
    end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'h1;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_out_instr;
  assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: a vector table for the main flows on a
// WB_LAT=3 instance, plus hand sequences for WB_LAT=1 and async reset.
module tb_issue_ctrl;

  localparam logic [31:0] I_A  = 32'h00221803; // r3 = r1 + r2
  localparam logic [31:0] I_B  = 32'h00222803; // r5 = r1 + r2
  localparam logic [31:0] I_D  = 32'h00612003; // r4 = r3 + r1
  localparam logic [31:0] I_E  = 32'h0C260005; // r6 = r1 + 5
  localparam logic [31:0] I_F  = 32'h00463807; // r7 = r2 & r6
  localparam logic [31:0] I_G  = 32'hFC050000; // unsupported I-type, rt=r5
  localparam logic [31:0] I_H  = 32'h00A03003; // r6 = r5 + r0
  localparam logic [31:0] I_D1 = 32'h00611803; // r3 = r3 + r1
  localparam logic [31:0] I_D2 = 32'h00621803;
  localparam logic [31:0] I_D3 = 32'h00631803;
  localparam logic [31:0] I_D4 = 32'h00641803;
  localparam logic [31:0] I_D5 = 32'h00651803;
  localparam logic [31:0] I_D6 = 32'h00661803;

  typedef struct {
    logic        fl;
    logic        vld;
    logic [31:0] ins;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_oi;
    logic [15:0] e_st;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        flush1 = 1'b0;
  logic [15:0] stall_count;
  logic [15:0] stall_count1;
  int          n_checks = 0;
  int          n_fail = 0;
  vec_t        vecs[$];
  logic [31:0] exp_q[$];

  issue_ctrl_if bus ();
  issue_ctrl_if bus1 ();

  issue_ctrl #(.DEPTH(4), .WB_LAT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .stall_count (stall_count)
  );

  issue_ctrl #(.DEPTH(4), .WB_LAT(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush1),
    .bus         (bus1),
    .stall_count (stall_count1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", what, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic vld, input logic [31:0] ins);
    flush           = fl;
    bus.in_valid    = vld;
    bus.in_instr    = ins;
  endtask

  task automatic drive1(input logic vld, input logic [31:0] ins);
    bus1.in_valid = vld;
    bus1.in_instr = ins;
  endtask

  function automatic void add(input logic fl, input logic vld, input logic [31:0] ins,
                              input logic rdy, input logic ov, input logic [31:0] oi,
                              input logic [15:0] st);
    vec_t v;
    v.fl = fl; v.vld = vld; v.ins = ins;
    v.e_rdy = rdy; v.e_ov = ov; v.e_oi = oi; v.e_st = st;
    vecs.push_back(v);
  endfunction

  task automatic check_outputs(input string tag, input logic rdy, input logic ov,
                               input logic [31:0] oi, input logic [15:0] st);
    check($sformatf("%s in_ready", tag), {31'b0, bus.in_ready}, {31'b0, rdy});
    check($sformatf("%s out_valid", tag), {31'b0, bus.out_valid}, {31'b0, ov});
    check($sformatf("%s out_instr", tag), bus.out_instr, oi);
    check($sformatf("%s stall_count", tag), {16'b0, stall_count}, {16'b0, st});
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0);
    drive1(1'b0, 32'h0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("reset", 1'b1, 1'b0, 32'h0, 16'h0);
    check("reset dut1 out_valid", {31'b0, bus1.out_valid}, 32'h0);
    check("reset dut1 in_ready", {31'b0, bus1.in_ready}, 32'h1);

    // independent stream
    add(0, 1, I_A,  1, 0, 32'h0, 0);
    add(0, 1, I_B,  1, 1, I_A,   0);
    add(0, 0, 0,    1, 1, I_B,   0);
    add(0, 0, 0,    1, 0, 32'h0, 0);
    add(0, 0, 0,    1, 0, 32'h0, 0);
    // RAW on R-type source rs: 1,0,0,1
    add(0, 1, I_A,  1, 0, 32'h0, 0);
    add(0, 1, I_D,  1, 1, I_A,   0);
    add(0, 0, 0,    1, 0, 32'h0, 1);
    add(0, 0, 0,    1, 0, 32'h0, 2);
    add(0, 0, 0,    1, 1, I_D,   2);
    add(0, 0, 0,    1, 0, 32'h0, 2);
    add(0, 0, 0,    1, 0, 32'h0, 2);
    // RAW on I-type dest feeding R-type rt
    add(0, 1, I_E,  1, 0, 32'h0, 2);
    add(0, 1, I_F,  1, 1, I_E,   2);
    add(0, 0, 0,    1, 0, 32'h0, 3);
    add(0, 0, 0,    1, 0, 32'h0, 4);
    add(0, 0, 0,    1, 1, I_F,   4);
    add(0, 0, 0,    1, 0, 32'h0, 4);
    add(0, 0, 0,    1, 0, 32'h0, 4);
    // unsupported encoding does not allocate, so its reader is not held
    add(0, 1, I_G,  1, 0, 32'h0, 4);
    add(0, 1, I_H,  1, 1, I_G,   4);
    add(0, 0, 0,    1, 1, I_H,   4);
    add(0, 0, 0,    1, 0, 32'h0, 4);
    // dependent chain fills the FIFO; D6 is pushed while full and dropped
    add(0, 1, I_A,  1, 0, 32'h0, 4);
    add(0, 1, I_D1, 1, 1, I_A,   4);
    add(0, 1, I_D2, 1, 0, 32'h0, 5);
    add(0, 1, I_D3, 1, 0, 32'h0, 6);
    add(0, 1, I_D4, 1, 1, I_D1,  6);
    add(0, 1, I_D5, 0, 0, 32'h0, 7);
    add(0, 1, I_D6, 0, 0, 32'h0, 8);
    add(0, 0, 0,    1, 1, I_D2,  8);
    add(0, 0, 0,    1, 0, 32'h0, 9);
    add(0, 0, 0,    1, 0, 32'h0, 10);
    add(0, 0, 0,    1, 1, I_D3,  10);
    add(0, 0, 0,    1, 0, 32'h0, 11);
    add(0, 0, 0,    1, 0, 32'h0, 12);
    add(0, 0, 0,    1, 1, I_D4,  12);
    add(0, 0, 0,    1, 0, 32'h0, 13);
    add(0, 0, 0,    1, 0, 32'h0, 14);
    add(0, 0, 0,    1, 1, I_D5,  14);
    add(0, 0, 0,    1, 0, 32'h0, 14);
    // flush with 3 queued, r3 still in the scoreboard, and a same-cycle push
    add(0, 1, I_A,  1, 0, 32'h0, 14);
    add(0, 1, I_D1, 1, 1, I_A,   14);
    add(0, 1, I_D2, 1, 0, 32'h0, 15);
    add(0, 1, I_D3, 1, 0, 32'h0, 16);
    add(1, 1, I_D4, 1, 0, 32'h0, 16);
    add(0, 1, I_D6, 1, 0, 32'h0, 16);
    add(0, 0, 0,    1, 1, I_D6,  16);
    add(0, 0, 0,    1, 0, 32'h0, 16);

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].vld, vecs[i].ins);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_ov,
                    vecs[i].e_oi, vecs[i].e_st);
    end
    drive(1'b0, 1'b0, 32'h0);

    // WB_LAT=1: the I-type producer and its consumer issue back to back
    begin
      logic exp_v[5];
      exp_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int c = 0; c < 5; c++) begin
        if (c == 0) begin drive1(1'b1, I_E); exp_q.push_back(I_E); end
        else if (c == 1) begin drive1(1'b1, I_F); exp_q.push_back(I_F); end
        else drive1(1'b0, 32'h0);
        @(negedge clk);
        check($sformatf("wb1 cyc%0d out_valid", c), {31'b0, bus1.out_valid}, {31'b0, exp_v[c]});
        if (exp_v[c] && exp_q.size() > 0)
          check($sformatf("wb1 cyc%0d out_instr", c), bus1.out_instr, exp_q.pop_front());
        else
          check($sformatf("wb1 cyc%0d bubble", c), bus1.out_instr, 32'h0);
      end
      check("wb1 stall_count", {16'b0, stall_count1}, 32'h0);
      check("wb1 queue drained", exp_q.size(), 0);
    end

    // asynchronous reset with an instruction on the bus and one queued
    drive(1'b0, 1'b1, I_A);
    @(negedge clk);
    drive(1'b0, 1'b1, I_D);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0);
    check_outputs("pre-reset", 1'b1, 1'b1, I_A, 16'd16);
    rst_n = 1'b0;
    #1;
    check_outputs("async reset", 1'b1, 1'b0, 32'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("post-reset idle", 1'b1, 1'b0, 32'h0, 16'h0);
    @(negedge clk);
    check_outputs("post-reset lost", 1'b1, 1'b0, 32'h0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
